// File: rtl/kernel_kcore_degree_update_pkg.sv
// Shared definitions for the k-core peeling stages: default widths and the
// per-vertex decision made in the degree-update stage.
package kernel_kcore_degree_update_pkg;

   localparam int unsigned DEF_VID_WIDTH  = 10;
   localparam int unsigned DEF_DEG_WIDTH  = 16;
   localparam int unsigned DEF_DATA_WIDTH = 32;

   // Outcome for the vertex in S2.
   typedef enum logic [1:0] {
      DecSkip,   // degree already below K: leave the table alone
      DecWrite,  // degree above K: decrement only
      DecEmit    // degree equals K: decrement and push to the next frontier
   } decision_e;

endpackage

// File: rtl/kernel_kcore_degree_update_if.sv
// FIFO-side handshake of the degree-update stage: read side of the upstream
// neighbour FIFO and write side of the downstream frontier FIFO.
interface kernel_kcore_degree_update_if
   import kernel_kcore_degree_update_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();

   logic                  in_empty_n;
   logic                  in_read;
   logic [DATA_WIDTH-1:0] in_dout;
   logic                  out_full_n;
   logic                  out_write;
   logic [DATA_WIDTH-1:0] out_din;

   // The stage itself.
   modport master (
      input  in_empty_n,
      input  in_dout,
      input  out_full_n,
      output in_read,
      output out_write,
      output out_din
   );

   // The FIFOs around it.
   modport slave (
      output in_empty_n,
      output in_dout,
      output out_full_n,
      input  in_read,
      input  out_write,
      input  out_din
   );

endinterface

// File: rtl/kernel_kcore_degree_update_ram.sv
// Degree table: one write port, one registered read port. A read and a write
// to the same address in one cycle return the old contents.
module kernel_kcore_degree_update_ram #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

   // Write and registered read; rdata holds when re is low.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/kernel_kcore_degree_update.sv
// k-core peeling stage: pops vertex IDs, decrements their degree while they
// are still in the core, and forwards vertices that just dropped below K.
module kernel_kcore_degree_update
   import kernel_kcore_degree_update_pkg::*;
#(
   parameter int unsigned VID_WIDTH  = DEF_VID_WIDTH,
   parameter int unsigned DEG_WIDTH  = DEF_DEG_WIDTH,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DEG_WIDTH-1:0] k_value,
   input  logic                 init_we,
   input  logic [VID_WIDTH-1:0] init_addr,
   input  logic [DEG_WIDTH-1:0] init_data,
   input  logic                 clr_cnt,
   output logic                 busy,
   output logic [31:0]          removed_cnt,
   kernel_kcore_degree_update_if.master fifo
);

   logic                 s2_valid_q;
   logic [VID_WIDTH-1:0] s2_vid_q;
   logic                 fwd_valid_q;
   logic [VID_WIDTH-1:0] fwd_addr_q;
   logic [DEG_WIDTH-1:0] fwd_data_q;
   logic [31:0]          cnt_q;

   logic [DEG_WIDTH-1:0] ram_q;
   logic [DEG_WIDTH-1:0] deg;
   logic [DEG_WIDTH-1:0] deg_dec;
   decision_e            decision;
   logic                 emit;
   logic                 stall;
   logic                 pop;
   logic                 s2_write;
   logic                 init_ok;
   logic                 ram_we;
   logic [VID_WIDTH-1:0] ram_waddr;
   logic [DEG_WIDTH-1:0] ram_wdata;

   // Upper FIFO word bits carry no vertex information here.
   logic unused_dout;
   assign unused_dout = ^fifo.in_dout[DATA_WIDTH-1:VID_WIDTH];

   // S2 decision, stall, pop and FIFO-side outputs.
   always_comb begin
      deg       = ram_q;
      decision  = DecSkip;
      fifo.out_din = '0;
      // Back-to-back hit: the table read raced the previous write-back.
      if (fwd_valid_q && (fwd_addr_q == s2_vid_q)) begin
         deg = fwd_data_q;
      end
      if (s2_valid_q) begin
         if (deg == k_value) begin
            decision = DecEmit;
         end else if (deg > k_value) begin
            decision = DecWrite;
         end
      end
      deg_dec        = deg - DEG_WIDTH'(1);
      emit           = (decision == DecEmit);
      stall          = emit & ~fifo.out_full_n;
      // Reset gates everything so in-flight vertices neither emit nor write.
      s2_write       = (decision != DecSkip) & ~stall & ~reset;
      pop            = fifo.in_empty_n & ~stall & ~reset;
      fifo.in_read   = pop;
      fifo.out_write = emit & fifo.out_full_n & ~reset;
      if (fifo.out_write) begin
         fifo.out_din = {{(DATA_WIDTH-VID_WIDTH){1'b0}}, s2_vid_q};
      end
      busy           = pop | s2_valid_q;
   end

   // Table write port: initialisation wins, and is only honoured when idle.
   always_comb begin
      init_ok   = init_we & ~busy;
      ram_we    = init_ok | s2_write;
      ram_waddr = s2_vid_q;
      ram_wdata = deg_dec;
      if (init_ok) begin
         ram_waddr = init_addr;
         ram_wdata = init_data;
      end
   end

   kernel_kcore_degree_update_ram #(
      .ADDR_WIDTH (VID_WIDTH),
      .DATA_WIDTH (DEG_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (pop),
      .raddr (fifo.in_dout[VID_WIDTH-1:0]),
      .rdata (ram_q)
   );

   // S2 stage and forwarding register; both freeze while stalled.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid_q  <= 1'b0;
         fwd_valid_q <= 1'b0;
      end else if (!stall) begin
         s2_valid_q  <= pop;
         s2_vid_q    <= fifo.in_dout[VID_WIDTH-1:0];
         // Cleared on bubbles too, so a stale entry never outlives an init.
         fwd_valid_q <= s2_write;
         fwd_addr_q  <= s2_vid_q;
         fwd_data_q  <= deg_dec;
      end
   end

   // Removed-vertex counter; a clear coinciding with an emit leaves 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr_cnt) begin
         cnt_q <= {31'b0, fifo.out_write};
      end else if (fifo.out_write) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign removed_cnt = cnt_q;

endmodule

// File: tb/tb_kernel_kcore_degree_update.sv
// Directed bench for the k-core degree-update stage.
module tb_kernel_kcore_degree_update;
   import kernel_kcore_degree_update_pkg::*;

   localparam int unsigned VW = DEF_VID_WIDTH;
   localparam int unsigned DW = DEF_DEG_WIDTH;
   localparam int Budget = 4000;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] k_value;
   logic          init_we;
   logic [VW-1:0] init_addr;
   logic [DW-1:0] init_data;
   logic          clr_cnt;
   logic          busy;
   logic [31:0]   removed_cnt;

   typedef struct {
      int          c;
      logic [31:0] d;
   } ev_t;

   ev_t         pops[$];
   ev_t         emits[$];
   logic [31:0] q[$];
   int          cyc = 0;
   logic        pop_pend = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   kernel_kcore_degree_update_if fif ();

   kernel_kcore_degree_update dut (
      .clk         (clk),
      .reset       (reset),
      .k_value     (k_value),
      .init_we     (init_we),
      .init_addr   (init_addr),
      .init_data   (init_data),
      .clr_cnt     (clr_cnt),
      .busy        (busy),
      .removed_cnt (removed_cnt),
      .fifo        (fif)
   );

   always #5 clk = ~clk;

   // Log handshakes mid-cycle, once everything has settled.
   always @(negedge clk) begin
      if (fif.in_read === 1'b1) begin
         pops.push_back('{cyc, fif.in_dout});
         pop_pend = 1'b1;
      end
      if (fif.out_write === 1'b1) begin
         emits.push_back('{cyc, fif.out_din});
      end
   end

   // Upstream FIFO model: head word presented just after each edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (pop_pend) begin
         if (q.size() != 0) q.delete(0);
         pop_pend = 1'b0;
      end
      fif.in_empty_n = (q.size() != 0);
      fif.in_dout    = (q.size() != 0) ? q[0] : 32'h0;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] emit_d(input int i);
      if (i < emits.size()) return emits[i].d;
      return 32'hFFFF_FFFF;
   endfunction

   function automatic int emit_c(input int i);
      if (i < emits.size()) return emits[i].c;
      return -1000;
   endfunction

   function automatic logic [31:0] pop_d(input int i);
      if (i < pops.size()) return pops[i].d;
      return 32'hFFFF_FFFF;
   endfunction

   function automatic int pop_c(input int i);
      if (i < pops.size()) return pops[i].c;
      return -1000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic init_deg(input int a, input int d);
      init_we   = 1'b1;
      init_addr = VW'(a);
      init_data = DW'(d);
      tick();
      init_we   = 1'b0;
   endtask

   task automatic clear_logs();
      pops.delete();
      emits.delete();
   endtask

   task automatic drain(input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while ((q.size() != 0 || busy) && n < Budget);
      check({tag, " drain timeout"}, 32'(n >= Budget), 32'd0);
   endtask

   initial begin
      int bad;
      int diff;
      reset          = 1'b1;
      k_value        = DW'(3);
      init_we        = 1'b0;
      init_addr      = '0;
      init_data      = '0;
      clr_cnt        = 1'b0;
      fif.out_full_n = 1'b1;
      tick();
      tick();
      check("rst in_read", 32'(fif.in_read), 0);
      check("rst out_write", 32'(fif.out_write), 0);
      check("rst out_din", fif.out_din, 0);
      check("rst busy", 32'(busy), 0);
      check("rst cnt", removed_cnt, 0);
      reset = 1'b0;
      tick();

      init_deg(5, 4);
      init_deg(7, 3);
      init_deg(9, 1);

      // Degree equal to K: emit one cycle after the pop.
      clear_logs();
      q.push_back(32'd7);
      drain("t1");
      check("t1 emits", 32'(emits.size()), 1);
      check("t1 din", emit_d(0), 7);
      check("t1 latency", 32'(emit_c(0) - pop_c(0)), 1);
      check("t1 cnt", removed_cnt, 1);

      // Back-to-back same vertex: second sees forwarded 3 and emits.
      clear_logs();
      q.push_back(32'd5);
      q.push_back(32'd5);
      drain("t2");
      check("t2 pops", 32'(pops.size()), 2);
      check("t2 back2back", 32'(pop_c(1) - pop_c(0)), 1);
      check("t2 emits", 32'(emits.size()), 1);
      check("t2 din", emit_d(0), 5);
      check("t2 latency", 32'(emit_c(0) - pop_c(1)), 1);
      check("t2 cnt", removed_cnt, 2);

      // Below K: no write, no emit.
      clear_logs();
      q.push_back(32'd9);
      q.push_back(32'd7);
      drain("t3");
      check("t3 pops", 32'(pops.size()), 2);
      check("t3 emits", 32'(emits.size()), 0);
      check("t3 cnt", removed_cnt, 2);

      // Read degrees back: emit happens iff degree equals K.
      k_value = DW'(2);
      clear_logs();
      q.push_back(32'd5);
      q.push_back(32'd7);
      drain("probe2");
      check("probe deg5/deg7 emits", 32'(emits.size()), 2);
      check("probe deg5==2", emit_d(0), 5);
      check("probe deg7==2", emit_d(1), 7);
      k_value = DW'(1);
      clear_logs();
      q.push_back(32'd9);
      drain("probe1");
      check("probe deg9==1", emit_d(0), 9);
      check("probe cnt", removed_cnt, 5);
      k_value = DW'(3);

      // Counter clear alone, then together with an emit.
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("clr cnt", removed_cnt, 0);
      init_deg(20, 3);
      clear_logs();
      q.push_back(32'd20);
      tick();
      tick();
      check("clr+emit out_write", 32'(fif.out_write), 1);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      check("clr+emit cnt", removed_cnt, 1);
      drain("clr");

      // Downstream full: hold everything, emit exactly once on release.
      init_deg(7, 3);
      fif.out_full_n = 1'b0;
      clear_logs();
      q.push_back(32'd7);
      q.push_back(32'd9);
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall in_read", 32'(fif.in_read), 0);
         check("stall out_write", 32'(fif.out_write), 0);
         check("stall busy", 32'(busy), 1);
         tick();
      end
      fif.out_full_n = 1'b1;
      drain("t4");
      check("t4 emits", 32'(emits.size()), 1);
      check("t4 din", emit_d(0), 7);
      check("t4 pops", 32'(pops.size()), 2);
      check("t4 pop0", pop_d(0), 7);
      check("t4 pop1", pop_d(1), 9);
      diff = pop_c(1) - emit_c(0);
      check("t4 resume", 32'(diff >= 0 && diff <= 1), 1);
      check("t4 cnt", removed_cnt, 2);

      // Full-table stream at one vertex per cycle.
      for (int i = 0; i < 1024; i++) init_deg(i, 3);
      clr_cnt = 1'b1;
      tick();
      clr_cnt = 1'b0;
      clear_logs();
      for (int i = 0; i < 1024; i++) q.push_back(32'(i));
      drain("t5");
      check("t5 emits", 32'(emits.size()), 1024);
      bad = 0;
      for (int i = 0; i < emits.size(); i++) begin
         if (emits[i].d != 32'(i)) bad++;
      end
      check("t5 order", 32'(bad), 0);
      check("t5 rate", 32'(emit_c(1023) - emit_c(0)), 1023);
      check("t5 cnt", removed_cnt, 1024);

      // Reset with two vertices in flight.
      init_deg(1, 3);
      init_deg(2, 3);
      clear_logs();
      q.push_back(32'd1);
      q.push_back(32'd2);
      tick();
      tick();
      check("t6 inflight busy", 32'(busy), 1);
      reset = 1'b1;
      tick();
      check("t6 busy", 32'(busy), 0);
      check("t6 out_write", 32'(fif.out_write), 0);
      check("t6 cnt", removed_cnt, 0);
      reset = 1'b0;
      drain("t6");
      check("t6 emits", 32'(emits.size()), 1);
      check("t6 din", emit_d(0), 2);
      check("t6 cnt after", removed_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
